// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the instruction into ALU op, operands and
// controls, then registers them into the EX slot. Flush beats stall beats load.
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [31:0]       pc_plus4,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_dest,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [31:0]       ex_branch_target,
  output logic              ex_illegal
);

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
                         ALU_SLT = 3'd4, ALU_NOR = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [2:0]        aluop;
    logic [DATA_W-1:0] store_data;
    logic [4:0]        dest;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic [31:0]       branch_target;
    logic              illegal;
  } ex_t;

  logic [5:0]  op, fn;
  logic [4:0]  rt, rd, sh;
  logic [15:0] imm;
  logic [DATA_W-1:0] simm, zimm, zsh;
  logic bad;
  ex_t dec, ex_q;

  assign op   = instr[31:26];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign sh   = instr[10:6];
  assign fn   = instr[5:0];
  assign imm  = instr[15:0];
  assign simm = {{(DATA_W-16){imm[15]}}, imm};
  assign zimm = {{(DATA_W-16){1'b0}}, imm};
  assign zsh  = {{(DATA_W-5){1'b0}}, sh};

  // Decode: defaults to a register-register I-type shape, opcode cases override.
  always_comb begin
    dec               = '0;
    bad               = 1'b0;
    dec.valid         = 1'b1;
    dec.in1           = rs_data;
    dec.in2           = rt_data;
    dec.store_data    = rt_data;
    dec.dest          = rt;
    dec.branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    case (op)
      6'h00: begin
        dec.dest     = rd;
        dec.regwrite = 1'b1;
        case (fn)
          6'h20: dec.aluop = ALU_ADD;
          6'h22: dec.aluop = ALU_SUB;
          6'h24: dec.aluop = ALU_AND;
          6'h25: dec.aluop = ALU_OR;
          6'h2A: dec.aluop = ALU_SLT;
          6'h27: dec.aluop = ALU_NOR;
          6'h00: begin dec.aluop = ALU_SLL; dec.in1 = rt_data; dec.in2 = zsh; end
          6'h02: begin dec.aluop = ALU_SRL; dec.in1 = rt_data; dec.in2 = zsh; end
          default: bad = 1'b1;
        endcase
      end
      6'h23: begin dec.aluop = ALU_ADD; dec.in2 = simm; dec.memread = 1'b1; dec.regwrite = 1'b1; end
      6'h2B: begin dec.aluop = ALU_ADD; dec.in2 = simm; dec.memwrite = 1'b1; end
      6'h04: begin dec.aluop = ALU_SUB; dec.branch = 1'b1; end
      6'h08: begin dec.aluop = ALU_ADD; dec.in2 = simm; dec.regwrite = 1'b1; end
      6'h0A: begin dec.aluop = ALU_SLT; dec.in2 = simm; dec.regwrite = 1'b1; end
      6'h0C: begin dec.aluop = ALU_AND; dec.in2 = zimm; dec.regwrite = 1'b1; end
      6'h0D: begin dec.aluop = ALU_OR;  dec.in2 = zimm; dec.regwrite = 1'b1; end
      default: bad = 1'b1;
    endcase
    // Unsupported encodings still occupy the slot but must not touch state.
    if (bad) begin
      dec.illegal  = 1'b1;
      dec.aluop    = ALU_ADD;
      dec.dest     = 5'd0;
      dec.regwrite = 1'b0;
      dec.memread  = 1'b0;
      dec.memwrite = 1'b0;
      dec.branch   = 1'b0;
    end
  end

  // EX slot register: flush or an invalid load inserts a bubble, stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      if (ZERO_BUBBLE) begin
        ex_q <= '0;
      end else begin
        ex_q.valid    <= 1'b0;
        ex_q.regwrite <= 1'b0;
        ex_q.memread  <= 1'b0;
        ex_q.memwrite <= 1'b0;
        ex_q.branch   <= 1'b0;
        ex_q.illegal  <= 1'b0;
      end
    end else if (!stall) begin
      ex_q <= dec;
    end
  end

  assign ex_valid         = ex_q.valid;
  assign ex_in1           = ex_q.in1;
  assign ex_in2           = ex_q.in2;
  assign ex_aluop         = ex_q.aluop;
  assign ex_store_data    = ex_q.store_data;
  assign ex_dest          = ex_q.dest;
  assign ex_regwrite      = ex_q.regwrite;
  assign ex_memread       = ex_q.memread;
  assign ex_memwrite      = ex_q.memwrite;
  assign ex_branch        = ex_q.branch;
  assign ex_branch_target = ex_q.branch_target;
  assign ex_illegal       = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model of the EX slot plus directed literals
// and randomized instruction/stall/flush traffic.
module tb_id_ex_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0, pc_plus4 = '0;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_branch_target;
  logic [2:0]  ex_aluop;
  logic [4:0]  ex_dest;

  id_ex_stage #(.DATA_W(32), .ZERO_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .rs_data(rs_data),
    .rt_data(rt_data), .pc_plus4(pc_plus4), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_aluop(ex_aluop),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_branch_target(ex_branch_target), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [31:0] in1, in2; logic [2:0] op; logic [31:0] sd; logic [4:0] dest;
    logic rw, mr, mw, br; logic [31:0] tgt; logic ill;
  } exp_t;

  int   n_chk = 0, n_fail = 0;
  exp_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // What the EX slot must contain after capturing one instruction.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [31:0] pc);
    exp_t e;
    int   opc, fun, simm;
    opc  = int'(ins >> 26);
    fun  = int'(ins & 32'h3F);
    simm = int'($signed(ins[15:0]));
    e = '0;
    e.v = 1'b1; e.sd = rt; e.tgt = pc + 32'(simm * 4);
    e.in1 = rs; e.in2 = rt; e.dest = ins[20:16];
    if (opc == 0) begin
      e.dest = ins[15:11]; e.rw = 1'b1;
      case (fun)
        'h20: e.op = 0;  'h22: e.op = 1;  'h24: e.op = 2;
        'h25: e.op = 3;  'h2A: e.op = 4;  'h27: e.op = 5;
        'h00, 'h02: begin
          e.op = (fun == 0) ? 3'd6 : 3'd7; e.in1 = rt; e.in2 = 32'(ins[10:6]);
        end
        default: begin e.ill = 1'b1; e.rw = 1'b0; end
      endcase
    end else begin
      case (opc)
        'h23: begin e.op = 0; e.in2 = simm; e.mr = 1'b1; e.rw = 1'b1; end
        'h2B: begin e.op = 0; e.in2 = simm; e.mw = 1'b1; end
        'h04: begin e.op = 1; e.br = 1'b1; end
        'h08: begin e.op = 0; e.in2 = simm; e.rw = 1'b1; end
        'h0A: begin e.op = 4; e.in2 = simm; e.rw = 1'b1; end
        'h0C: begin e.op = 2; e.in2 = {16'h0, ins[15:0]}; e.rw = 1'b1; end
        'h0D: begin e.op = 3; e.in2 = {16'h0, ins[15:0]}; e.rw = 1'b1; end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Reference EX slot, updated on the same events as the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else if (flush || (!stall && !in_valid)) m <= '0;
    else if (!stall) m <= model(instr, rs_data, rt_data, pc_plus4);
  end

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
    chk({tag, ".rw"}, 32'(ex_regwrite), 32'(e.rw));
    chk({tag, ".mr"}, 32'(ex_memread), 32'(e.mr));
    chk({tag, ".mw"}, 32'(ex_memwrite), 32'(e.mw));
    chk({tag, ".br"}, 32'(ex_branch), 32'(e.br));
    chk({tag, ".ill"}, 32'(ex_illegal), 32'(e.ill));
    chk({tag, ".sd"}, ex_store_data, e.sd);
    chk({tag, ".tgt"}, ex_branch_target, e.tgt);
    // Operands/op/dest of an illegal instruction carry no meaning.
    if (!e.ill) begin
      chk({tag, ".in1"}, ex_in1, e.in1);
      chk({tag, ".in2"}, ex_in2, e.in2);
      chk({tag, ".op"}, 32'(ex_aluop), 32'(e.op));
      chk({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
    end
  endtask

  // Every falling edge out of reset: DUT against the model, plus the bubble invariant.
  always @(negedge clk) begin
    if (!rst) begin
      chk_all("cyc", m);
      if (!ex_valid)
        chk("invariant", {27'h0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal}, 32'h0);
    end
  end

  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] pc,
                      input logic st, input logic fl);
    in_valid = iv; instr = ins; rs_data = rs; rt_data = rt; pc_plus4 = pc;
    stall = st; flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'h0);
    chk({tag, ".ctl"}, {27'h0, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal}, 32'h0);
    chk({tag, ".data"}, ex_in1 | ex_in2 | ex_store_data | ex_branch_target, 32'h0);
    chk({tag, ".opdest"}, {24'h0, ex_aluop, ex_dest}, 32'h0);
  endtask

  logic [31:0] snap_in1, snap_tgt;
  logic [4:0]  snap_dest;
  logic [31:0] ins_r;
  logic [5:0]  ops [9] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D};
  logic [5:0]  fns [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h02, 6'h08, 6'h3F};

  initial begin
    #1 chk_zero("reset");
    #3 rst = 1'b0;

    // 1: add $2,$4,$5
    step(1, 32'h00851020, 7, 5, 32'h100, 0, 0);
    chk("t1.in1", ex_in1, 7); chk("t1.in2", ex_in2, 5); chk("t1.op", 32'(ex_aluop), 0);
    chk("t1.dest", 32'(ex_dest), 2); chk("t1.rw", 32'(ex_regwrite), 1);
    chk("t1.valid", 32'(ex_valid), 1);
    chk("t1.model", m.in1 + m.in2 + 32'(m.dest), 14);
    // 2: lw $8,-4($9)
    step(1, 32'h8D28FFFC, 32'h100, 3, 32'h104, 0, 0);
    chk("t2.in1", ex_in1, 32'h100); chk("t2.in2", ex_in2, 32'hFFFFFFFC);
    chk("t2.op", 32'(ex_aluop), 0); chk("t2.mr", 32'(ex_memread), 1);
    chk("t2.rw", 32'(ex_regwrite), 1); chk("t2.dest", 32'(ex_dest), 8);
    chk("t2.model", m.in2, 32'hFFFFFFFC);
    // 3: sll $3,$6,4
    step(1, 32'h00061900, 9, 1, 32'h108, 0, 0);
    chk("t3.in1", ex_in1, 1); chk("t3.in2", ex_in2, 4);
    chk("t3.op", 32'(ex_aluop), 6); chk("t3.dest", 32'(ex_dest), 3);
    // 4: beq backwards and wrapping target
    step(1, 32'h1022FFFF, 4, 4, 32'h00400010, 0, 0);
    chk("t4.br", 32'(ex_branch), 1); chk("t4.op", 32'(ex_aluop), 1);
    chk("t4.rw", 32'(ex_regwrite), 0); chk("t4.tgt", ex_branch_target, 32'h0040000C);
    chk("t4.model", m.tgt, 32'h0040000C);
    step(1, 32'h10220001, 4, 4, 32'hFFFFFFFC, 0, 0);
    chk("t4.wrap", ex_branch_target, 32'h0);
    // nop encoding is legal
    step(1, 32'h00000000, 1, 2, 32'h0, 0, 0);
    chk("nop.ill", 32'(ex_illegal), 0); chk("nop.valid", 32'(ex_valid), 1);
    // 5: stall holds for 3 cycles despite new inputs
    step(1, 32'h3402BEEF, 32'h11, 32'h22, 32'h200, 0, 0);
    snap_in1 = ex_in1; snap_tgt = ex_branch_target; snap_dest = ex_dest;
    for (int i = 0; i < 3; i++) begin
      step(1, $urandom, $urandom, $urandom, $urandom, 1, 0);
      chk("t5.hold.in1", ex_in1, snap_in1); chk("t5.hold.tgt", ex_branch_target, snap_tgt);
      chk("t5.hold.dest", 32'(ex_dest), 32'(snap_dest)); chk("t5.hold.in2", ex_in2, 32'hBEEF);
    end
    step(1, 32'h00851020, 7, 5, 32'h0, 1, 1);
    chk_zero("t5.stallflush");
    step(1, 32'h00851020, 7, 5, 32'h0, 0, 0);
    step(0, 32'h00851020, 7, 5, 32'h0, 0, 0);
    chk_zero("t5.invalid");
    // 6: undefined opcode, then async reset between edges
    step(1, 32'hFC000000, 1, 2, 32'h40, 0, 0);
    chk("t6.valid", 32'(ex_valid), 1); chk("t6.ill", 32'(ex_illegal), 1);
    chk("t6.ctl", {28'h0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 0);
    step(1, 32'h2108FFFF, 5, 6, 32'h80, 0, 0);
    rst = 1'b1; #1 chk_zero("t6.rst");
    #1 rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ins_r = $urandom;
      if ($urandom_range(0, 9) != 0) ins_r[31:26] = ops[$urandom_range(0, 8)];
      if (ins_r[31:26] == 6'h00) ins_r[5:0] = fns[$urandom_range(0, 9)];
      step($urandom_range(0, 9) != 0, ins_r, $urandom, $urandom, $urandom,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
